// File: rtl/slc3_mem_pkg.sv
// Shared types and address decode for the SLC-3 memory-side responder.
// Keeps the region rules in one place so every user agrees on RAM/IO/OOR.
package slc3_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_HOLD
   } resp_state_t;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_IO,
      REG_OOR
   } region_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
   localparam int unsigned LAT_W           = 3;

   // The IO word wins over RAM should it ever sit inside the RAM window.
   function automatic region_t decode_region(input logic [19:0]  addr,
                                             input logic [15:0]  io_addr,
                                             input int unsigned  depth_log2);
      if (addr[19:16] == 4'h0 && addr[15:0] == io_addr) return REG_IO;
      if ((addr >> depth_log2) == 20'h0)                 return REG_RAM;
      return REG_OOR;
   endfunction

endpackage

// File: rtl/slc3_mem_responder_byte_ram.sv
// Single-port synchronous RAM, 16-bit words split into two byte lanes,
// with independent byte write enables and a registered read port.
module byte_ram #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we_hi,
   input  logic              i_we_lo,
   input  logic [15:0]       i_wdata,
   output logic [15:0]       o_rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [7:0]  r_mem_hi [DEPTH];
   logic [7:0]  r_mem_lo [DEPTH];
   logic [15:0] r_rdata;

   // NOTE: storage arrays carry no reset so they map onto block RAM; contents are undefined at power-up.
   always_ff @(posedge i_clk) begin
      if (i_we_hi) r_mem_hi[i_addr] <= i_wdata[15:8];
      if (i_we_lo) r_mem_lo[i_addr] <= i_wdata[7:0];
      r_rdata <= {r_mem_hi[i_addr], r_mem_lo[i_addr]};
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 SRAM-style bus: byte-lane RAM,
// one memory-mapped IO word (switches/hex), fixed read latency, sticky error.
module slc3_mem_responder
   import slc3_mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned READ_LAT   = 2,
   parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_CE,
   input  logic        Mem_UB,
   input  logic        Mem_LB,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic [19:0] ADDR,
   input  logic [15:0] Data_from_cpu,
   output logic [15:0] Data_to_cpu,
   output logic        Data_valid,
   input  logic [15:0] Switches,
   output logic [15:0] Hex_out,
   output logic        Err
);

   resp_state_t r_state, w_next_state;
   region_t     r_region, w_region;

   logic [19:0]      r_addr;
   logic [15:0]      r_wdata;
   logic             r_ub, r_lb;
   logic [LAT_W-1:0] r_cnt;
   logic [15:0]      r_data;
   logic             r_valid;
   logic [15:0]      r_hex;
   logic             r_err;
   logic [15:0]      r_sw_meta, r_sw_sync;

   logic                  w_req, w_read_abort, w_hold_keep;
   logic                  w_capture, w_read_done, w_commit, w_hold_exit, w_cnt_dec;
   logic [DEPTH_LOG2-1:0] w_ram_addr;
   logic                  w_ram_we_hi, w_ram_we_lo;
   logic [15:0]           w_ram_q, w_rd_raw, w_rd_masked;

   assign w_req        = ~Mem_CE & (~Mem_OE | ~Mem_WE);
   assign w_read_abort = Mem_CE | Mem_OE;
   assign w_hold_keep  = w_req && (ADDR == r_addr);
   assign w_region     = decode_region(ADDR, IO_ADDR, DEPTH_LOG2);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_req) w_next_state = Mem_WE ? ST_READ : ST_WRITE;
         ST_READ: begin
            if (w_read_abort)        w_next_state = ST_IDLE;
            else if (r_cnt == '0)    w_next_state = ST_HOLD;
         end
         ST_WRITE: w_next_state = ST_HOLD;
         ST_HOLD:  if (!w_hold_keep) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_capture   = 1'b0;
      w_read_done = 1'b0;
      w_commit    = 1'b0;
      w_hold_exit = 1'b0;
      w_cnt_dec   = 1'b0;
      unique case (r_state)
         ST_IDLE:  w_capture = w_req;
         ST_READ: begin
            w_read_done = !w_read_abort && (r_cnt == '0);
            w_cnt_dec   = !w_read_abort && (r_cnt != '0);
         end
         ST_WRITE: w_commit    = 1'b1;
         ST_HOLD:  w_hold_exit = !w_hold_keep;
         default:  ;
      endcase
   end

   // In IDLE the RAM is addressed straight from the bus so its one-cycle
   // read is already under way on the capture edge.
   assign w_ram_addr  = (r_state == ST_IDLE) ? ADDR[DEPTH_LOG2-1:0] : r_addr[DEPTH_LOG2-1:0];
   assign w_ram_we_hi = w_commit && (r_region == REG_RAM) && r_ub;
   assign w_ram_we_lo = w_commit && (r_region == REG_RAM) && r_lb;

   byte_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
      .i_clk   (Clk),
      .i_addr  (w_ram_addr),
      .i_we_hi (w_ram_we_hi),
      .i_we_lo (w_ram_we_lo),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   always_comb begin
      w_rd_raw = 16'h0000;
      unique case (r_region)
         REG_RAM: w_rd_raw = w_ram_q;
         REG_IO:  w_rd_raw = r_sw_sync;
         default: w_rd_raw = 16'h0000;
      endcase
      w_rd_masked = {r_ub ? w_rd_raw[15:8] : 8'h00, r_lb ? w_rd_raw[7:0] : 8'h00};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ub      <= 1'b0;
         r_lb      <= 1'b0;
         r_region  <= REG_RAM;
         r_cnt     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_hex     <= '0;
         r_err     <= 1'b0;
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= Switches;
         r_sw_sync <= r_sw_meta;

         if (w_capture) begin
            r_addr   <= ADDR;
            r_wdata  <= Data_from_cpu;
            r_ub     <= ~Mem_UB;
            r_lb     <= ~Mem_LB;
            r_region <= w_region;
            r_cnt    <= LAT_W'(READ_LAT - 1);
            if (w_region == REG_OOR) r_err <= 1'b1;
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_read_done) begin
            r_data  <= w_rd_masked;
            r_valid <= 1'b1;
         end
         if (w_hold_exit) r_valid <= 1'b0;

         if (w_commit && r_region == REG_IO) begin
            if (r_ub) r_hex[15:8] <= r_wdata[15:8];
            if (r_lb) r_hex[7:0]  <= r_wdata[7:0];
         end
      end
   end

   assign Data_to_cpu = r_data;
   assign Data_valid  = r_valid;
   assign Hex_out     = r_hex;
   assign Err         = r_err;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: directed corner cases, then
// randomized accesses compared against a word-array reference model.
`timescale 1ns/1ps
module tb_slc3_mem_responder;

   localparam int unsigned DEPTH_LOG2 = 10;
   localparam int unsigned READ_LAT   = 2;
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
   logic [19:0] ADDR;
   logic [15:0] Data_from_cpu;
   logic [15:0] Data_to_cpu;
   logic        Data_valid;
   logic [15:0] Switches;
   logic [15:0] Hex_out;
   logic        Err;

   slc3_mem_responder #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .READ_LAT   (READ_LAT),
      .IO_ADDR    (16'hFFFF)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Mem_CE        (Mem_CE),
      .Mem_UB        (Mem_UB),
      .Mem_LB        (Mem_LB),
      .Mem_OE        (Mem_OE),
      .Mem_WE        (Mem_WE),
      .ADDR          (ADDR),
      .Data_from_cpu (Data_from_cpu),
      .Data_to_cpu   (Data_to_cpu),
      .Data_valid    (Data_valid),
      .Switches      (Switches),
      .Hex_out       (Hex_out),
      .Err           (Err)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: word array plus the visible output registers.
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_hex  = 16'h0000;
   logic [15:0] m_data = 16'h0000;
   logic        m_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // 0 = RAM, 1 = IO, 2 = out of range
   function automatic int region_of(input logic [19:0] a);
      if (a == 20'h0FFFF)   return 1;
      if (a < 20'(DEPTH))   return 0;
      return 2;
   endfunction

   function automatic logic [15:0] lanes(input logic [15:0] d, input bit ub, input bit lb);
      return {ub ? d[15:8] : 8'h00, lb ? d[7:0] : 8'h00};
   endfunction

   task automatic bus_idle();
      Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
      Mem_UB = 1'b1; Mem_LB = 1'b1;
   endtask

   task automatic drive(input bit wr, input logic [19:0] a, input bit ub, input bit lb,
                        input logic [15:0] wd);
      ADDR          = a;
      Mem_UB        = !ub;
      Mem_LB        = !lb;
      Data_from_cpu = wd;
      Mem_WE        = !wr;
      Mem_OE        = wr ? 1'($urandom_range(0, 1)) : 1'b0;
      Mem_CE        = 1'b0;
   endtask

   // One complete bus transaction with latency, data, hex and error checks.
   task automatic access(input bit wr, input logic [19:0] a, input bit ub, input bit lb,
                         input logic [15:0] wd);
      int          r;
      logic [15:0] exp;
      r = region_of(a);
      @(negedge Clk);
      drive(wr, a, ub, lb, wd);
      @(posedge Clk); #1;
      if (r == 2) m_err = 1'b1;
      check("err_at_capture", Err, m_err);
      if (wr) begin
         check("hex_before_commit", Hex_out, m_hex);
         if (r == 0) begin
            if (ub) m_mem[a[DEPTH_LOG2-1:0]][15:8] = wd[15:8];
            if (lb) m_mem[a[DEPTH_LOG2-1:0]][7:0]  = wd[7:0];
         end else if (r == 1) begin
            if (ub) m_hex[15:8] = wd[15:8];
            if (lb) m_hex[7:0]  = wd[7:0];
         end
         @(posedge Clk); #1;
         check("hex_after_commit", Hex_out, m_hex);
         check("valid_on_write", Data_valid, 1'b0);
      end else begin
         if (r == 0)      exp = lanes(m_mem[a[DEPTH_LOG2-1:0]], ub, lb);
         else if (r == 1) exp = lanes(Switches, ub, lb);
         else             exp = 16'h0000;
         for (int i = 1; i < int'(READ_LAT); i++) begin
            @(posedge Clk); #1;
            check("valid_early", Data_valid, 1'b0);
         end
         @(posedge Clk); #1;
         check("valid_rise", Data_valid, 1'b1);
         check("read_data", Data_to_cpu, exp);
         m_data = exp;
      end
      @(posedge Clk); #1;
      check("hold_valid", Data_valid, !wr);
      check("hold_data", Data_to_cpu, m_data);
      @(negedge Clk);
      bus_idle();
      @(posedge Clk); #1;
      check("release_valid", Data_valid, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      int          sel;
      logic [19:0] a;

      Reset = 1'b1;
      bus_idle();
      ADDR = '0; Data_from_cpu = '0; Switches = 16'h0000;
      repeat (2) @(negedge Clk);
      check("rst_data", Data_to_cpu, 16'h0000);
      check("rst_valid", Data_valid, 1'b0);
      check("rst_hex", Hex_out, 16'h0000);
      check("rst_err", Err, 1'b0);
      Reset = 1'b0;

      // Fill RAM so every model word is defined.
      for (int i = 0; i < int'(DEPTH); i++) access(1'b1, 20'(i), 1'b1, 1'b1, 16'($urandom));

      access(1'b1, 20'h00012, 1'b1, 1'b1, 16'hBEEF);
      access(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      check("beef_readback", Data_to_cpu, 16'hBEEF);
      access(1'b1, 20'h00012, 1'b1, 1'b0, 16'h1234);
      access(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      check("ub_merge", Data_to_cpu, 16'h12EF);
      access(1'b0, 20'h00012, 1'b0, 1'b1, 16'h0000);
      check("lb_only_read", Data_to_cpu, 16'h00EF);
      access(1'b0, 20'h00012, 1'b0, 1'b0, 16'h0000);
      check("no_lane_read", Data_to_cpu, 16'h0000);

      access(1'b1, 20'h0FFFF, 1'b1, 1'b1, 16'hCAFE);
      check("hex_cafe", Hex_out, 16'hCAFE);
      @(negedge Clk); Switches = 16'h00A5;
      repeat (3) @(posedge Clk);
      access(1'b0, 20'h0FFFF, 1'b1, 1'b1, 16'h0000);
      check("switch_read", Data_to_cpu, 16'h00A5);

      access(1'b0, 20'h10000, 1'b1, 1'b1, 16'h0000);
      check("oor_read_zero", Data_to_cpu, 16'h0000);
      check("oor_err_set", Err, 1'b1);
      access(1'b1, 20'h00400, 1'b1, 1'b1, 16'h5A5A);
      access(1'b0, 20'h00000, 1'b1, 1'b1, 16'h0000);
      access(1'b0, 20'h003FF, 1'b1, 1'b1, 16'h0000);
      check("err_sticky", Err, 1'b1);

      // Asynchronous reset in the middle of a read.
      access(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      @(negedge Clk);
      drive(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      @(posedge Clk); #3;
      Reset = 1'b1;
      bus_idle();
      #1;
      check("async_rst_data", Data_to_cpu, 16'h0000);
      check("async_rst_valid", Data_valid, 1'b0);
      check("async_rst_hex", Hex_out, 16'h0000);
      check("async_rst_err", Err, 1'b0);
      m_hex = 16'h0000; m_err = 1'b0; m_data = 16'h0000;
      @(negedge Clk); @(negedge Clk);
      Reset = 1'b0;
      access(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      check("post_rst_read", Data_to_cpu, 16'h12EF);

      // Read abort: OE drops one cycle into READ.
      @(negedge Clk);
      drive(1'b0, 20'h003FF, 1'b1, 1'b1, 16'h0000);
      @(posedge Clk); #1;
      @(negedge Clk); Mem_OE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         check("abort_valid", Data_valid, 1'b0);
         check("abort_data", Data_to_cpu, m_data);
      end
      @(negedge Clk); bus_idle();

      // Address change while holding read data.
      @(negedge Clk);
      drive(1'b0, 20'h00012, 1'b1, 1'b1, 16'h0000);
      @(posedge Clk);
      repeat (READ_LAT) @(posedge Clk);
      #1;
      check("hold_first_valid", Data_valid, 1'b1);
      check("hold_first_data", Data_to_cpu, m_mem[10'h012]);
      @(negedge Clk); ADDR = 20'h003FF;
      @(posedge Clk); #1;
      check("hold_exit_valid", Data_valid, 1'b0);
      for (int i = 0; i < int'(READ_LAT); i++) begin
         @(posedge Clk); #1;
         check("rearm_valid_low", Data_valid, 1'b0);
      end
      @(posedge Clk); #1;
      check("rearm_valid_high", Data_valid, 1'b1);
      check("rearm_data", Data_to_cpu, m_mem[10'h3FF]);
      m_data = m_mem[10'h3FF];
      @(negedge Clk); bus_idle();
      @(posedge Clk); #1;

      // Randomized traffic across all regions and lane combinations.
      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            6:       a = ($urandom_range(0, 1) != 0) ? 20'h003FF : 20'h00000;
            7:       a = 20'h0FFFF;
            8:       a = 20'($urandom_range(32'h400, 32'hFFFE));
            9:       a = {4'($urandom_range(1, 15)), 16'($urandom)};
            default: a = 20'($urandom_range(0, DEPTH - 1));
         endcase
         if ($urandom_range(0, 7) == 0) begin
            @(negedge Clk); Switches = 16'($urandom);
            repeat (2) @(posedge Clk);
         end
         d = 16'($urandom);
         access(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
